pcm_fifo_sync: RTL and testbench

Parametrised synchronous FIFO that buffers PCM audio samples between the microphone capture path and the downstream consumer (filter/serialiser). It generalises the existing single-bit-data FIFO to configurable width and depth. It adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush.

---
 rtl/pcm_fifo_pkg.sv | 32 +++
 rtl/pcm_fifo_ram.sv | 38 +++
 rtl/pcm_fifo_sync.sv | 104 ++++++++++
 tb/tb_pcm_fifo_sync.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pcm_fifo_pkg.sv
// PCM FIFO shared helpers: width math and
// configuration sanity check.
package pcm_fifo_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int addr_w(input int depth);
    return (depth < 2) ? 1 : clog2(depth);
  endfunction

  function automatic int lvl_w(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic bit cfg_ok(
    input int width,
    input int depth,
    input int ae,
    input int af
  );
    return (width >= 1) && (width <= 32) &&
           (depth >= 4) && (depth <= 1024) &&
           ((depth & (depth - 1)) == 0) &&
           (ae < af) && (af <= depth);
  endfunction

endpackage

// File: rtl/pcm_fifo_ram.sv
// PCM FIFO storage array; read port is registered,
// or asynchronous when PCM_FIFO_FWFT_EN is defined.
module pcm_fifo_ram
  import pcm_fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef PCM_FIFO_FWFT_EN
  logic unused_ok;
  assign unused_ok = ^{rst_n, re};
  assign rdata = mem[raddr];
`else
  // Read-before-write: a pop on a full FIFO sees the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/pcm_fifo_sync.sv
// PCM sample FIFO with level, thresholds, sticky errors, flush.
// Define PCM_FIFO_FWFT_EN for first-word-fall-through output.
module pcm_fifo_sync
  import pcm_fifo_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int DEPTH     = 16,
  parameter  int AF_THRESH = DEPTH - 2,
  parameter  int AE_THRESH = 2,
  localparam int AW        = addr_w(DEPTH),
  localparam int LW        = lvl_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [LW-1:0]    level,
  output logic             overflow,
  output logic             underflow
);

  if (!cfg_ok(WIDTH, DEPTH, AE_THRESH, AF_THRESH)) begin : g_cfg_bad
    $error("pcm_fifo_sync: bad DEPTH/threshold setup");
  end

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;
  logic [LW-1:0] level_nxt;
  logic          wr_acc;
  logic          rd_acc;

  assign wr_acc = wr && (!full || rd);
  assign rd_acc = rd && !empty;

  always_comb begin
    level_nxt = level;
    unique case (1'b1)
      (wr_acc && !rd_acc): level_nxt = level + 1'b1;
      (rd_acc && !wr_acc): level_nxt = level - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      level        <= level_nxt;
      full         <= (level_nxt == DEPTH_L);
      empty        <= (level_nxt == '0);
      almost_full  <= (level_nxt >= AF_L);
      almost_empty <= (level_nxt <= AE_L);
      overflow     <= overflow | (wr && full && !rd);
      underflow    <= underflow | (rd && empty);
    end
  end

  pcm_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clock),
    .rst_n (reset),
    .we    (wr_acc && !flush),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (din),
    .re    (rd_acc && !flush),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (dout)
  );

endmodule

// File: tb/tb_pcm_fifo_sync.sv
// Directed bench for pcm_fifo_sync, default build,
// WIDTH=16 DEPTH=16 AF=14 AE=2.
module tb_pcm_fifo_sync;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        wr    = 1'b0;
  logic        rd    = 1'b0;
  logic [15:0] din   = '0;
  logic [15:0] dout;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [4:0]  level;
  logic        overflow;
  logic        underflow;

  pcm_fifo_sync #(
    .WIDTH (16),
    .DEPTH (16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .flush        (flush),
    .wr           (wr),
    .din          (din),
    .rd           (rd),
    .dout         (dout),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .level        (level),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic        rd;
    logic        fl;
    logic [15:0] din;
    logic [15:0] dout;
    logic [4:0]  lvl;
    logic        ovf;
    logic        unf;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  function automatic void add(
    input logic        w,
    input logic        r,
    input logic        f,
    input logic [15:0] d,
    input logic [15:0] q,
    input logic [4:0]  l,
    input logic        o,
    input logic        u
  );
    vec_t v;
    v.wr = w; v.rd = r; v.fl = f; v.din = d;
    v.dout = q; v.lvl = l; v.ovf = o; v.unf = u;
    vecs.push_back(v);
  endfunction

  function automatic logic [26:0] exp_of(
    input logic [15:0] q,
    input logic [4:0]  l,
    input logic        o,
    input logic        u
  );
    return {q, l, l == 5'd16, l == 5'd0,
            l >= 5'd14, l <= 5'd2, o, u};
  endfunction

  function automatic logic [26:0] status();
    return {dout, level, full, empty, almost_full,
            almost_empty, overflow, underflow};
  endfunction

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic [15:0] q[$];
  logic [15:0] last;
  int          wcnt;

  initial begin
    // 1: fill to full, thresholds along the way
    for (int i = 0; i < 16; i++)
      add(1, 0, 0, 16'(i + 1), 16'h0, 5'(i + 1), 0, 0);
    // 2: write while full is dropped
    add(1, 0, 0, 16'hBEEF, 16'h0, 5'd16, 1, 0);
    // 3: simultaneous wr/rd while full
    add(1, 1, 0, 16'h00AA, 16'h0001, 5'd16, 1, 0);
    for (int k = 0; k < 16; k++)
      add(0, 1, 0, 16'h0,
          (k < 15) ? 16'(k + 2) : 16'h00AA,
          5'(15 - k), 1, 0);
    // 4: wr/rd on empty: write only, underflow
    add(1, 1, 0, 16'h1234, 16'h00AA, 5'd1, 1, 1);
    add(0, 1, 0, 16'h0, 16'h1234, 5'd0, 1, 1);
    // flush wins over wr, clears errors, dout holds
    add(1, 0, 1, 16'h7777, 16'h1234, 5'd0, 0, 0);
    add(0, 1, 0, 16'h0, 16'h1234, 5'd0, 0, 1);
    add(0, 1, 1, 16'h0, 16'h1234, 5'd0, 0, 0);

    #12;
    chk("reset_state", 32'(status()),
        32'(exp_of(16'h0, 5'd0, 0, 0)));
    reset = 1'b1;
    tick();

    foreach (vecs[i]) begin
      wr = vecs[i].wr; rd = vecs[i].rd;
      flush = vecs[i].fl; din = vecs[i].din;
      tick();
      chk($sformatf("vec%0d", i), 32'(status()),
          32'(exp_of(vecs[i].dout, vecs[i].lvl,
                     vecs[i].ovf, vecs[i].unf)));
    end
    wr = 0; rd = 0; flush = 0;

    // 5: 3-write/2-read bursts across the address wrap
    wcnt = 0;
    last = '0;
    while (wcnt < 20 || q.size() > 0) begin
      for (int j = 0; j < 3; j++) begin
        if (wcnt < 20) begin
          wr = 1; din = 16'h0100 + 16'(wcnt);
          tick();
          q.push_back(din);
          wcnt++;
          chk("burst_wlvl", 32'(level), 32'(q.size()));
        end
      end
      wr = 0;
      for (int j = 0; j < 2; j++) begin
        if (q.size() > 0) begin
          rd = 1;
          tick();
          last = q.pop_front();
          chk("burst_dout", 32'(dout), 32'(last));
          chk("burst_rlvl", 32'(level), 32'(q.size()));
        end
      end
      rd = 0;
    end
    chk("burst_last", 32'(last), 32'h0113);

    for (int j = 0; j < 5; j++) begin
      wr = 1; din = 16'h0300 + 16'(j);
      tick();
    end
    wr = 0;
    chk("pre_flush_lvl", 32'(level), 32'd5);
    flush = 1;
    tick();
    flush = 0;
    chk("flush_at5", 32'(status()),
        32'(exp_of(16'h0113, 5'd0, 0, 0)));

    // 6: asynchronous reset mid-burst at level 7
    for (int j = 0; j < 7; j++) begin
      wr = 1; din = 16'h0200 + 16'(j);
      tick();
    end
    wr = 0;
    rd = 1;
    tick();
    rd = 0;
    chk("pre_rst_lvl", 32'(level), 32'd6);
    chk("pre_rst_dout", 32'(dout), 32'h0200);
    wr = 1; din = 16'h0207;
    tick();
    wr = 0;
    chk("pre_rst_lvl7", 32'(level), 32'd7);
    #2 reset = 1'b0;
    #1;
    chk("async_rst", 32'(status()),
        32'(exp_of(16'h0, 5'd0, 0, 0)));
    #1 reset = 1'b1;
    wr = 1; din = 16'h0055;
    tick();
    wr = 0;
    chk("post_rst_lvl", 32'(level), 32'd1);
    rd = 1;
    tick();
    rd = 0;
    chk("post_rst_rd", 32'(status()),
        32'(exp_of(16'h0055, 5'd0, 0, 0)));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
